mult_sequencer: RTL and testbench

//  Multi-cycle shift-add multiplier controller. Replaces the single-cycle combinational

---
 rtl/mult_sequencer.sv | 173 +++++++++++++++++
 tb/tb_mult_sequencer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_sequencer.sv
// mult_sequencer: multi-cycle shift-add multiplier controller.
// Retires STEP multiplier bits per cycle, producing a WIDTH-bit product in
// WIDTH/STEP cycles behind a start/busy/done handshake for the pipeline stall.
// Signed multiplies work on operand magnitudes; the product is negated at the end.
// Optional feature: define MULT_HI_EN to add the result_hi port (upper product word).
// Without it the accumulator is trimmed to WIDTH bits.
module mult_sequencer #(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op_unsign,
    input  logic [WIDTH-1:0] busA,
    input  logic [WIDTH-1:0] busB,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
`ifdef MULT_HI_EN
    ,
    output logic [WIDTH-1:0] result_hi
`endif
);

    localparam int NSTEPS = WIDTH / STEP;
    localparam int CNT_W  = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;
`ifdef MULT_HI_EN
    localparam int ACC_W  = 2 * WIDTH;
`else
    localparam int ACC_W  = WIDTH;
`endif
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSTEPS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Magnitude of an operand; the most-negative value maps to 2^(WIDTH-1),
    // which is representable because the magnitude is treated as unsigned.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic             is_signed);
        magnitude = (is_signed && v[WIDTH-1]) ? -v : v;
    endfunction

    // Final sign correction of the unsigned magnitude product.
    function automatic logic [ACC_W-1:0] apply_sign(input logic [ACC_W-1:0] p,
                                                    input logic             neg);
        apply_sign = neg ? -p : p;
    endfunction

    // One partial product: multiplicand times the current STEP-bit digit,
    // aligned to the digit position.
    function automatic logic [ACC_W-1:0] partial(input logic [WIDTH-1:0] mcand,
                                                 input logic [STEP-1:0]  digit,
                                                 input logic [CNT_W-1:0] cnt);
        logic [WIDTH+STEP-1:0] pp;
        int                    sh;
        pp      = (WIDTH+STEP)'(mcand) * (WIDTH+STEP)'(digit);
        sh      = int'(cnt) * STEP;
        partial = ACC_W'(pp) << sh;
    endfunction

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_accept;
    logic                w_last;

    logic [WIDTH-1:0]    r_mcand;
    logic [WIDTH-1:0]    r_mplier;
    logic                r_neg;
    logic [CNT_W-1:0]    r_cnt;
    logic [ACC_W-1:0]    r_acc;
    logic [WIDTH-1:0]    r_result;
`ifdef MULT_HI_EN
    logic [WIDTH-1:0]    r_result_hi;
`endif

    logic [ACC_W-1:0]    w_acc_nxt;
    logic [ACC_W-1:0]    w_prod;

    assign w_last    = (r_cnt == LAST_CNT);
    assign w_acc_nxt = r_acc + partial(r_mcand, r_mplier[STEP-1:0], r_cnt);
    assign w_prod    = apply_sign(w_acc_nxt, r_neg);

    assign result    = r_result;
`ifdef MULT_HI_EN
    assign result_hi = r_result_hi;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and state-decoded handshake outputs.
    // start is only looked at outside CALC; flush only matters inside CALC,
    // which also gives it priority over a start in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_CALC;
                end
            end
            S_CALC: begin
                busy = 1'b1;
                if (flush) begin
                    w_state_nxt = S_IDLE;
                end else if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_CALC;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Operand capture, shift-add iteration and result update on entry to DONE.
    // result is left untouched by a flushed operation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_neg       <= 1'b0;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_result    <= '0;
`ifdef MULT_HI_EN
            r_result_hi <= '0;
`endif
        end else if (w_accept) begin
            r_mcand  <= magnitude(busA, !op_unsign);
            r_mplier <= magnitude(busB, !op_unsign);
            r_neg    <= !op_unsign && (busA[WIDTH-1] ^ busB[WIDTH-1]);
            r_cnt    <= '0;
            r_acc    <= '0;
        end else if ((r_state == S_CALC) && !flush) begin
            r_acc    <= w_acc_nxt;
            r_mplier <= r_mplier >> STEP;
            r_cnt    <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_result    <= w_prod[WIDTH-1:0];
`ifdef MULT_HI_EN
                r_result_hi <= w_prod[2*WIDTH-1:WIDTH];
`endif
            end
        end
    end

endmodule

// File: tb/tb_mult_sequencer.sv
// Directed testbench for mult_sequencer (default WIDTH=32, STEP=1).
// Upper-word checks are active when MULT_HI_EN is defined.
module tb_mult_sequencer;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         op_unsign;
    logic [W-1:0] busA;
    logic [W-1:0] busB;
    logic         flush;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
`ifdef MULT_HI_EN
    logic [W-1:0] result_hi;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mult_sequencer #(.WIDTH(W), .STEP(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op_unsign (op_unsign),
        .busA      (busA),
        .busB      (busB),
        .flush     (flush),
        .busy      (busy),
        .done      (done),
        .result    (result)
`ifdef MULT_HI_EN
        ,
        .result_hi (result_hi)
`endif
    );

    // Advance one cycle; "cycle k" is the interval just after the k-th edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive a start request in the current cycle.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic uns);
        busA      = a;
        busB      = b;
        op_unsign = uns;
        start     = 1'b1;
    endtask

    // Step until done (bounded); cyc = cycle of done, or -1 on timeout.
    task automatic wait_done(input int max_cyc, output int cyc);
        cyc = -1;
        for (int k = 1; k <= max_cyc; k++) begin
            step();
            if (k == 1) start = 1'b0;
            if (done) begin
                cyc = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; flush = 1'b0; op_unsign = 1'b0; busA = '0; busB = '0;
        step();
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result got %h want 0", result); end
`ifdef MULT_HI_EN
        checks++; if (result_hi !== 32'h0) begin errors++; $display("FAIL reset_result_hi got %h want 0", result_hi); end
`endif
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_unsigned_basic();
        int first_busy = -1;
        int last_busy  = -1;
        int done_cyc   = -1;
        int done_cnt   = 0;
        logic [W-1:0] res_at_done = '0;
        launch(32'd7, 32'd6, 1'b1);
        for (int k = 1; k <= 40; k++) begin
            step();
            if (k == 1) start = 1'b0;
            if (busy) begin
                if (first_busy < 0) first_busy = k;
                last_busy = k;
            end
            if (done) begin
                done_cnt++;
                done_cyc    = k;
                res_at_done = result;
            end
        end
        checks++; if (first_busy != 1) begin errors++; $display("FAIL u7x6_first_busy got %0d want 1", first_busy); end
        checks++; if (last_busy != 32) begin errors++; $display("FAIL u7x6_last_busy got %0d want 32", last_busy); end
        checks++; if (done_cyc != 33) begin errors++; $display("FAIL u7x6_done_cycle got %0d want 33", done_cyc); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL u7x6_done_count got %0d want 1", done_cnt); end
        checks++; if (res_at_done !== 32'd42) begin errors++; $display("FAIL u7x6_result got %0d want 42", res_at_done); end
        checks++; if (result !== 32'd42) begin errors++; $display("FAIL u7x6_result_held got %0d want 42", result); end
    endtask

    task automatic test_signed_small();
        int cyc;
        step();
        launch(32'hFFFFFFFD, 32'd5, 1'b0);
        wait_done(40, cyc);
        checks++; if (cyc != 33) begin errors++; $display("FAIL s_m3x5_done_cycle got %0d want 33", cyc); end
        checks++; if (result !== 32'hFFFFFFF1) begin errors++; $display("FAIL s_m3x5_result got %h want fffffff1", result); end
`ifdef MULT_HI_EN
        checks++; if (result_hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL s_m3x5_hi got %h want ffffffff", result_hi); end
`endif
    endtask

    task automatic test_full_scale();
        int cyc;
        step();
        launch(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
        wait_done(40, cyc);
        checks++; if (result !== 32'h00000001) begin errors++; $display("FAIL u_max_result got %h want 00000001", result); end
`ifdef MULT_HI_EN
        checks++; if (result_hi !== 32'hFFFFFFFE) begin errors++; $display("FAIL u_max_hi got %h want fffffffe", result_hi); end
`endif
        step();
        launch(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        wait_done(40, cyc);
        checks++; if (result !== 32'h00000001) begin errors++; $display("FAIL s_m1xm1_result got %h want 00000001", result); end
`ifdef MULT_HI_EN
        checks++; if (result_hi !== 32'h00000000) begin errors++; $display("FAIL s_m1xm1_hi got %h want 00000000", result_hi); end
`endif
    endtask

    task automatic test_most_negative();
        int cyc;
        step();
        launch(32'h80000000, 32'hFFFFFFFF, 1'b0);
        wait_done(40, cyc);
        checks++; if (result !== 32'h80000000) begin errors++; $display("FAIL s_minxm1_result got %h want 80000000", result); end
`ifdef MULT_HI_EN
        checks++; if (result_hi !== 32'h00000000) begin errors++; $display("FAIL s_minxm1_hi got %h want 00000000", result_hi); end
`endif
        step();
        launch(32'h80000000, 32'h80000000, 1'b0);
        wait_done(40, cyc);
        checks++; if (result !== 32'h00000000) begin errors++; $display("FAIL s_minxmin_result got %h want 00000000", result); end
`ifdef MULT_HI_EN
        checks++; if (result_hi !== 32'h40000000) begin errors++; $display("FAIL s_minxmin_hi got %h want 40000000", result_hi); end
`endif
        step();
        launch(32'h80000000, 32'h00000002, 1'b1);
        wait_done(40, cyc);
        checks++; if (result !== 32'h00000000) begin errors++; $display("FAIL u_minx2_result got %h want 00000000", result); end
`ifdef MULT_HI_EN
        checks++; if (result_hi !== 32'h00000001) begin errors++; $display("FAIL u_minx2_hi got %h want 00000001", result_hi); end
`endif
    endtask

    task automatic test_back_to_back();
        int done_cnt = 0;
        int first_done = -1;
        int second_done = -1;
        logic [W-1:0] res1 = '0;
        logic [W-1:0] res2 = '0;
        logic busy34 = 1'b0;
        step();
        step();
        launch(32'd2, 32'd3, 1'b1);
        for (int k = 1; k <= 70; k++) begin
            step();
            if (done) begin
                done_cnt++;
                if (first_done < 0) begin first_done = k; res1 = result; end
                else begin second_done = k; res2 = result; end
            end
            if (k == 34) busy34 = busy;
            if (k == 1)  start = 1'b0;
            if (k == 10) begin busA = 32'd9; busB = 32'd9; start = 1'b1; end
            if (k == 11) start = 1'b0;
            if (k == 33) begin busA = 32'd4; busB = 32'd5; op_unsign = 1'b1; start = 1'b1; end
            if (k == 34) start = 1'b0;
        end
        checks++; if (first_done != 33) begin errors++; $display("FAIL b2b_first_done got %0d want 33", first_done); end
        checks++; if (res1 !== 32'd6) begin errors++; $display("FAIL b2b_ignored_start_result got %0d want 6", res1); end
        checks++; if (busy34 !== 1'b1) begin errors++; $display("FAIL b2b_busy_c34 got %b want 1", busy34); end
        checks++; if (second_done != 66) begin errors++; $display("FAIL b2b_second_done got %0d want 66", second_done); end
        checks++; if (res2 !== 32'd20) begin errors++; $display("FAIL b2b_second_result got %0d want 20", res2); end
        checks++; if (done_cnt != 2) begin errors++; $display("FAIL b2b_done_count got %0d want 2", done_cnt); end
    endtask

    task automatic test_flush();
        int done_cnt = 0;
        int cyc;
        logic busy6 = 1'b1;
        step();
        launch(32'd4, 32'd4, 1'b1);
        for (int k = 1; k <= 40; k++) begin
            step();
            if (done) done_cnt++;
            if (k == 6) busy6 = busy;
            if (k == 1) start = 1'b0;
            if (k == 5) flush = 1'b1;
            if (k == 6) flush = 1'b0;
        end
        checks++; if (busy6 !== 1'b0) begin errors++; $display("FAIL flush_busy_c6 got %b want 0", busy6); end
        checks++; if (done_cnt != 0) begin errors++; $display("FAIL flush_done_count got %0d want 0", done_cnt); end
        checks++; if (result !== 32'd20) begin errors++; $display("FAIL flush_result_kept got %0d want 20", result); end
        launch(32'd3, 32'd3, 1'b1);
        wait_done(40, cyc);
        checks++; if (cyc != 33) begin errors++; $display("FAIL flush_next_done got %0d want 33", cyc); end
        checks++; if (result !== 32'd9) begin errors++; $display("FAIL flush_next_result got %0d want 9", result); end
    endtask

    task automatic test_reset_mid();
        int done_cnt = 0;
        step();
        launch(32'd5, 32'd5, 1'b1);
        for (int k = 1; k <= 40; k++) begin
            step();
            if (k == 1) start = 1'b0;
            if (k == 13) begin
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", busy); end
                checks++; if (done !== 1'b0) begin errors++; $display("FAIL rstmid_done got %b want 0", done); end
                checks++; if (result !== 32'd0) begin errors++; $display("FAIL rstmid_result got %0d want 0", result); end
`ifdef MULT_HI_EN
                checks++; if (result_hi !== 32'd0) begin errors++; $display("FAIL rstmid_hi got %0d want 0", result_hi); end
`endif
                rst_n = 1'b1;
            end
            if (k > 13 && done) done_cnt++;
            if (k == 12) rst_n = 1'b0;
        end
        checks++; if (done_cnt != 0) begin errors++; $display("FAIL rstmid_done_after got %0d want 0", done_cnt); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_unsigned_basic();
        test_signed_small();
        test_full_scale();
        test_most_negative();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
